// File: rtl/arith_dispatch_pkg.sv
// arith_dispatch_pkg: shared types and widths for the arith_dispatch block.
//   op_e        - operation select (OP_ADD / OP_MUL)
//   res_entry_t - one result-FIFO entry {op, data, tag}
// The tag field is sized for the widest supported tag; narrower tags are
// zero-extended on push and truncated on read.
package arith_dispatch_pkg;

    localparam int unsigned OPND_W    = 4;   // operand width
    localparam int unsigned ARES_W    = 5;   // adder result width
    localparam int unsigned MRES_W    = 8;   // multiplier result width
    localparam int unsigned DATA_W    = 8;   // result data width on out_data
    localparam int unsigned TAG_MAX_W = 16;  // widest supported TAG_W

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } op_e;

    typedef struct packed {
        op_e                    op;
        logic [DATA_W-1:0]      data;
        logic [TAG_MAX_W-1:0]   tag;
    } res_entry_t;

endpackage

// File: rtl/arith_dispatch_fifo.sv
// arith_dispatch_fifo: synchronous result FIFO, DEPTH entries (power of 2).
//   clk, rst  - clock, asynchronous active-high reset
//   push_i    - write din_i (ignored when full)
//   din_i     - entry to write
//   pop_i     - drop head entry (ignored when empty)
//   dout_o    - head entry, zero when empty
//   valid_o   - FIFO not empty
//   count_o   - number of stored entries (0..DEPTH)
// No bypass: an entry pushed into an empty FIFO is visible the next cycle.
module arith_dispatch_fifo
    import arith_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  res_entry_t               din_i,
    input  logic                     pop_i,
    output res_entry_t               dout_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    res_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of 2.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din_i;
    end

    assign valid_o = (count_q != '0);
    assign dout_o  = valid_o ? mem[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/arith_dispatch.sv
// arith_dispatch: dispatches add/multiply requests to external 1-cycle units
// and returns tagged results in acceptance order through a credit-managed FIFO.
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - request handshake; in_op 0=add 1=mul; in_a, in_b operands
//   aa, ab / ma, mb      - registered operands to the adder / multiplier
//   aout / mout          - registered unit results (one clock after operands)
//   out_valid/out_ready  - result handshake; out_op, out_data, out_tag = FIFO head
// Optional (macro ARITH_DISPATCH_STATS_EN): add_cnt, mul_cnt saturating op counters.
module arith_dispatch
    import arith_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_op,
    input  logic [OPND_W-1:0]   in_a,
    input  logic [OPND_W-1:0]   in_b,
    output logic [OPND_W-1:0]   aa,
    output logic [OPND_W-1:0]   ab,
    output logic [OPND_W-1:0]   ma,
    output logic [OPND_W-1:0]   mb,
    input  logic [ARES_W-1:0]   aout,
    input  logic [MRES_W-1:0]   mout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_op,
    output logic [DATA_W-1:0]   out_data,
`ifdef ARITH_DISPATCH_STATS_EN
    output logic [15:0]         add_cnt,
    output logic [15:0]         mul_cnt,
`endif
    output logic [TAG_W-1:0]    out_tag
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned CRD_W = CNT_W + 1;  // holds DEPTH + 2

    logic [OPND_W-1:0] aa_q, ab_q, ma_q, mb_q;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              s1_valid_q, s2_valid_q;
    op_e               s1_op_q, s2_op_q;
    logic [TAG_W-1:0]  s1_tag_q, s2_tag_q;

    logic              accept;
    logic [CNT_W-1:0]  fifo_count;
    logic [CRD_W-1:0]  credits_used;
    res_entry_t        push_entry, head;

    // Every accepted op reserves a FIFO slot until popped, so a push never
    // finds the FIFO full. Only registered state feeds in_ready.
    assign credits_used = CRD_W'(fifo_count) + CRD_W'(s1_valid_q) + CRD_W'(s2_valid_q);
    assign in_ready     = !rst && (credits_used < CRD_W'(DEPTH));
    assign accept       = in_valid && in_ready;
    assign tag_d        = accept ? tag_q + TAG_W'(1) : tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aa_q       <= '0;
            ab_q       <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            tag_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ADD;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_op_q    <= OP_ADD;
            s2_tag_q   <= '0;
        end else begin
            if (accept && (op_e'(in_op) == OP_ADD)) begin
                aa_q <= in_a;
                ab_q <= in_b;
            end
            if (accept && (op_e'(in_op) == OP_MUL)) begin
                ma_q <= in_a;
                mb_q <= in_b;
            end
            tag_q      <= tag_d;
            s1_valid_q <= accept;
            s1_op_q    <= op_e'(in_op);
            s1_tag_q   <= tag_q;
            s2_valid_q <= s1_valid_q;
            s2_op_q    <= s1_op_q;
            s2_tag_q   <= s1_tag_q;
        end
    end

    // S2 means the unit's result register now holds this op's result.
    always_comb begin
        push_entry      = '0;
        push_entry.op   = s2_op_q;
        push_entry.data = (s2_op_q == OP_MUL) ? DATA_W'(mout) : DATA_W'(aout);
        push_entry.tag  = TAG_MAX_W'(s2_tag_q);
    end

    arith_dispatch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s2_valid_q),
        .din_i   (push_entry),
        .pop_i   (out_valid && out_ready),
        .dout_o  (head),
        .valid_o (out_valid),
        .count_o (fifo_count)
    );

    assign aa       = aa_q;
    assign ab       = ab_q;
    assign ma       = ma_q;
    assign mb       = mb_q;
    assign out_op   = head.op;
    assign out_data = head.data;
    assign out_tag  = head.tag[TAG_W-1:0];

`ifdef ARITH_DISPATCH_STATS_EN
    logic [15:0] add_cnt_q, mul_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_cnt_q <= '0;
            mul_cnt_q <= '0;
        end else begin
            if (accept && (op_e'(in_op) == OP_ADD) && (add_cnt_q != 16'hFFFF)) begin
                add_cnt_q <= add_cnt_q + 16'd1;
            end
            if (accept && (op_e'(in_op) == OP_MUL) && (mul_cnt_q != 16'hFFFF)) begin
                mul_cnt_q <= mul_cnt_q + 16'd1;
            end
        end
    end

    assign add_cnt = add_cnt_q;
    assign mul_cnt = mul_cnt_q;
`endif

endmodule

// File: doc/arith_dispatch.md
ARITH_DISPATCH -- requirements
Module: arith_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result-FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter TAG_W, default 4, width of the transaction tag.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports in_valid in 1 and in_ready out 1: request handshake.
REQ-007 SHALL have port in_op  in  1  0 = add, 1 = multiply.
REQ-008 SHALL have ports in_a, in_b  in  4 each  unsigned operands.
REQ-009 SHALL have ports aa, ab  out  4 each  registered operands to the adder unit.
REQ-010 SHALL have ports ma, mb  out  4 each  registered operands to the multiplier unit.
REQ-011 SHALL have ports aout in 5 and mout in 8: registered results from the adder and multiplier units (1-clock latency).
REQ-012 SHALL have ports out_valid out 1 and out_ready in 1: result handshake.
REQ-013 SHALL have ports out_op out 1, out_data out 8 (add result zero-extended), out_tag out TAG_W.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid && in_ready.
REQ-015 On accept: load in_a/in_b into aa/ab (add) or ma/mb (mul); the other unit's operand registers SHALL hold.
REQ-016 SHALL track in-flight ops with a 2-stage valid/op/tag pipeline: S1 = operands presented, S2 = unit result valid.
REQ-017 On the edge after S2 is set, SHALL push {op, aout or mout, tag} into the result FIFO; accept at edge E0 gives push at E2 and out_valid high in the cycle after E2.
REQ-018 SHALL drive in_ready = (fifo_count + S1 + S2) < DEPTH, computed only from registered state (no combinational path from out_ready or in_valid).
REQ-019 Pushed entries are never dropped: the credit rule guarantees the FIFO is never full on push.
REQ-020 SHALL pop on a rising edge where out_valid && out_ready; out_* SHALL present the FIFO head and hold stable while out_valid && !out_ready.
REQ-021 Push and pop on the same edge: count unchanged; on an empty FIFO there is no bypass, and the pushed entry appears the next cycle.
REQ-022 The tag counter SHALL increment by 1 per accept, wrapping 2^TAG_W-1 -> 0.
REQ-023 Results SHALL be delivered in acceptance order.

Reset
REQ-024 While rst is high: aa, ab, ma, mb, out_data, out_op, out_tag = 0; out_valid = 0; in_ready = 0; tag counter = 0; S1/S2 cleared; FIFO empty.
REQ-025 Reset mid-operation SHALL discard all in-flight and queued results; in_ready = 1 in the first cycle after deassertion.

Configuration
REQ-026 With macro ARITH_DISPATCH_STATS_EN defined: outputs add_cnt and mul_cnt (16 bits each) SHALL count accepted add/mul ops, saturate at 16'hFFFF, and reset to 0.
REQ-027 Without ARITH_DISPATCH_STATS_EN: those ports and counters SHALL be absent.

Structure
REQ-028 Package arith_dispatch_pkg SHALL hold the op enum (OP_ADD = 0, OP_MUL = 1), operand/result width constants and the result-entry struct {op, data, tag}.
REQ-029 The result FIFO SHALL be sub-module arith_dispatch_fifo (synchronous, count output, DEPTH parameter, same clk/rst).

Verification
REQ-030 Single add 9 + 7, tag 0: aa = 9, ab = 7 after E0; out_data = 8'h10, out_op = 0, out_tag = 0, out_valid in the cycle after E2.
REQ-031 Single mul 15 * 15: out_data = 8'hE1, out_op = 1; aa/ab unchanged from the prior add.
REQ-032 out_ready = 0 with continuous in_valid: exactly DEPTH (4) accepts, then in_ready = 0; the first pop re-raises in_ready the next cycle; no result is lost.
REQ-033 Seventeen back-to-back ops with out_ready = 1: one result per cycle in order, tags 0..15, 0.
REQ-034 rst pulsed asynchronously while 2 ops are in flight and 2 are queued: out_valid drops immediately; no stale result appears after release; the next tag = 0.
REQ-035 With ARITH_DISPATCH_STATS_EN: 3 adds and 2 muls give add_cnt = 3, mul_cnt = 2.
